// File: rtl/joybus_pkg.sv
// Shared types and default timing for the joybus poll/receive stages.
package joybus_pkg;

  localparam int unsigned NBITS_DEF       = 32;
  localparam int unsigned THRESH_CYC_DEF  = 200;
  localparam int unsigned TIMEOUT_CYC_DEF = 1000;

  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t WAIT_START = 3'd1;
  localparam state_t LOW        = 3'd2;
  localparam state_t HIGH       = 3'd3;
  localparam state_t HOLD       = 3'd4;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_NORESP = 2'd1;
  localparam logic [1:0] ERR_STUCK  = 2'd2;
  localparam logic [1:0] ERR_SHORT  = 2'd3;

endpackage

// File: rtl/joybus_rx_if.sv
// Frame handshake between the joybus receiver (master) and the APB read slave (slave).
interface joybus_rx_if
  import joybus_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF
);
  logic [NBITS-1:0] frame_data;
  logic             frame_valid;
  logic             frame_ack;

  modport master (output frame_data, output frame_valid, input frame_ack);
  modport slave  (input frame_data, input frame_valid, output frame_ack);
endinterface

// File: rtl/joybus_edge_sync.sv
// Line synchronizer with rise/fall detect; optional 3-sample glitch filter
// enabled by JOYBUS_RX_GLITCH_FILTER_EN.
module joybus_edge_sync (
  input  logic PCLK,
  input  logic PRESERN,
  input  logic line_in,
  output logic rise,
  output logic fall
);
  logic sync1_q, sync2_q, s_prev_q, s;

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      sync1_q  <= line_in;
      sync2_q  <= sync1_q;
      s_prev_q <= s;
    end
  end

`ifdef JOYBUS_RX_GLITCH_FILTER_EN
  logic d1_q, d2_q, s_hold_q;

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      d1_q     <= 1'b1;
      d2_q     <= 1'b1;
      s_hold_q <= 1'b1;
    end else begin
      d1_q     <= sync2_q;
      d2_q     <= d1_q;
      s_hold_q <= s;
    end
  end

  // Follow the line only once the three newest synchronized samples agree.
  always_comb begin
    s = s_hold_q;
    if ((sync2_q == d1_q) && (d1_q == d2_q)) s = sync2_q;
  end
`else
  assign s = sync2_q;
`endif

  assign rise = ~s_prev_q & s;
  assign fall = s_prev_q & ~s;

endmodule

// File: rtl/joybus_rx.sv
// Decodes the controller's pulse-width-coded reply into one word held under valid/ack.
// Optional input glitch filter: define JOYBUS_RX_GLITCH_FILTER_EN.
module joybus_rx
  import joybus_pkg::*;
#(
  parameter int unsigned NBITS       = NBITS_DEF,
  parameter int unsigned THRESH_CYC  = THRESH_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        line_in,
  input  logic        arm,
  joybus_rx_if.master frame,
  output logic        busy,
  output logic        err_pulse,
  output logic [1:0]  err_code
);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BitW = $clog2(NBITS + 1);

  logic             rise, fall, timeout;
  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BitW-1:0]  bitcnt_q, bitcnt_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic             frame_valid_q, frame_valid_d;
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_code_q, err_code_d;

  joybus_edge_sync u_edge_sync (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .line_in (line_in),
    .rise    (rise),
    .fall    (fall)
  );

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYC));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    frame_valid_d = frame_valid_q;
    err_pulse_d   = 1'b0;
    err_code_d    = err_code_q;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = WAIT_START;
          bitcnt_d   = '0;
          err_code_d = ERR_NONE;
        end
      end
      WAIT_START: begin
        if (fall) begin
          state_d = LOW;
        end else if (timeout) begin
          state_d     = IDLE;
          err_code_d  = ERR_NORESP;
          err_pulse_d = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          if (bitcnt_q < BitW'(NBITS)) begin
            // cnt_q misses the cycle that sees the rise, so it is one short of the low length.
            shift_d  = {shift_q[NBITS-2:0], (cnt_q < CntW'(THRESH_CYC - 1))};
            bitcnt_d = bitcnt_q + BitW'(1);
            state_d  = HIGH;
          end else begin
            state_d = HOLD;
          end
        end else if (timeout) begin
          state_d     = IDLE;
          err_code_d  = ERR_STUCK;
          err_pulse_d = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
        end else if (timeout) begin
          state_d     = IDLE;
          err_code_d  = ERR_SHORT;
          err_pulse_d = 1'b1;
        end
      end
      HOLD: begin
        if (!frame_valid_q) begin
          frame_valid_d = 1'b1;
        end else if (frame.frame_ack) begin
          frame_valid_d = 1'b0;
          if (arm) begin
            state_d    = WAIT_START;
            bitcnt_d   = '0;
            err_code_d = ERR_NONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d != state_q) || rise || fall) begin
      cnt_d = '0;
    end else if (!timeout) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      frame_valid_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      frame_valid_q <= frame_valid_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
    end
  end

  assign frame.frame_data  = shift_q;
  assign frame.frame_valid = frame_valid_q;
  assign busy      = (state_q == WAIT_START) || (state_q == LOW) || (state_q == HIGH);
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_joybus_rx.sv
// Bench for joybus_rx: vector table, randomized frames against a pulse-width model,
// and hand sequences for errors, handshake corners and reset.
module tb_joybus_rx;
  localparam int NB  = 32;
  localparam int THR = 200;
  localparam int TMO = 1000;
`ifdef JOYBUS_RX_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  typedef struct {
    logic [31:0] word;
    int          one_low;
    int          zero_low;
    int          period;
    logic [31:0] exp;
  } vec_t;

  logic       PCLK = 1'b0;
  logic       PRESERN = 1'b0;
  logic       line_in = 1'b0;
  logic       arm = 1'b0;
  logic       busy, err_pulse;
  logic [1:0] err_code;

  joybus_rx_if #(.NBITS(NB)) fif ();

  joybus_rx #(
    .NBITS       (NB),
    .THRESH_CYC  (THR),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .PCLK      (PCLK),
    .PRESERN   (PRESERN),
    .line_in   (line_in),
    .arm       (arm),
    .frame     (fif),
    .busy      (busy),
    .err_pulse (err_pulse),
    .err_code  (err_code)
  );

  always #5 PCLK = ~PCLK;

  int   n_checks = 0;
  int   n_fail = 0;
  int   err_cnt = 0;
  int   overlap_cnt = 0;
  int   low_len[NB+1];
  int   high_len[NB];
  vec_t vec[4];

  always @(posedge PCLK) begin
    if (err_pulse) err_cnt <= err_cnt + 1;
    if (err_pulse && fif.frame_valid) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: each low pulse shorter than THR cycles is a '1', first pulse is the MSB.
  function automatic logic [31:0] model_word();
    logic [31:0] w = '0;
    for (int i = 0; i < NB; i++) w = {w[30:0], (low_len[i] < THR)};
    return w;
  endfunction

  task automatic fill_table(input int t);
    for (int i = 0; i < NB; i++) begin
      low_len[i]  = vec[t].word[31-i] ? vec[t].one_low : vec[t].zero_low;
      high_len[i] = vec[t].period - low_len[i];
    end
    low_len[NB] = 60;
  endtask

  task automatic fill_random();
    logic [31:0] w = $urandom;
    for (int i = 0; i < NB; i++) begin
      low_len[i]  = w[31-i] ? int'($urandom_range(5, 199)) : int'($urandom_range(200, 300));
      high_len[i] = int'($urandom_range(5, 40));
    end
    low_len[NB] = int'($urandom_range(20, 80));
  endtask

  task automatic arm_pulse(input string name);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check({name, "_busy_after_arm"}, 32'(busy), 1);
  endtask

  task automatic drive_bits(input int n);
    for (int i = 0; i < n; i++) begin
      line_in = 1'b0;
      ticks(low_len[i]);
      line_in = 1'b1;
      ticks(high_len[i]);
    end
  endtask

  task automatic finish_frame(input string name, input logic [31:0] exp);
    line_in = 1'b0;
    ticks(low_len[NB]);
    line_in = 1'b1;
    ticks(LAT - 1);
    check({name, "_valid_early"}, 32'(fif.frame_valid), 0);
    tick();
    check({name, "_valid_latency"}, 32'(fif.frame_valid), 1);
    check({name, "_data"}, fif.frame_data, exp);
    check({name, "_busy_in_hold"}, 32'(busy), 0);
    check({name, "_err_code"}, 32'(err_code), 0);
  endtask

  task automatic ack_frame(input string name, input logic [31:0] exp);
    ticks(3);
    check({name, "_data_held"}, fif.frame_data, exp);
    check({name, "_valid_held"}, 32'(fif.frame_valid), 1);
    fif.frame_ack = 1'b1;
    tick();
    fif.frame_ack = 1'b0;
    check({name, "_valid_cleared"}, 32'(fif.frame_valid), 0);
  endtask

  task automatic expect_error(input string name, input logic [1:0] code);
    int base = err_cnt;
    bit got = 1'b0;
    for (int i = 0; i < TMO + 100 && !got; i++) begin
      tick();
      if (err_cnt != base) got = 1'b1;
    end
    check({name, "_err_seen"}, 32'(got), 1);
    ticks(5);
    check({name, "_err_once"}, err_cnt - base, 1);
    check({name, "_err_code"}, 32'(err_code), 32'(code));
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_valid"}, 32'(fif.frame_valid), 0);
  endtask

  initial begin
    logic [31:0] exp;
    int          base;

    vec[0] = '{32'hA5F0_0C3A, 100, 300, 400, 32'hA5F0_0C3A};
    vec[1] = '{32'hFFFF_0000, 199, 200, 230, 32'hFFFF_0000};
    vec[2] = '{32'h1234_5678, 200, 200, 220, 32'h0000_0000};
    vec[3] = '{32'h0F0F_0F0F, 10,  199, 220, 32'hFFFF_FFFF};
    fif.frame_ack = 1'b0;

    // Reset with the line held low and a stray arm.
    ticks(3);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    check("rst_valid", 32'(fif.frame_valid), 0);
    check("rst_data", fif.frame_data, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err_pulse", 32'(err_pulse), 0);
    check("rst_err_code", 32'(err_code), 0);
    line_in = 1'b1;
    ticks(2);
    PRESERN = 1'b1;
    ticks(5);
    check("idle_busy", 32'(busy), 0);

    for (int t = 0; t < 4; t++) begin
      string nm = $sformatf("vec%0d", t);
      fill_table(t);
      arm_pulse(nm);
      ticks(10);
      drive_bits(NB);
      finish_frame(nm, vec[t].exp);
      ack_frame(nm, vec[t].exp);
      ticks(5);
    end

    // HOLD corners: lone arm ignored, then ack+arm re-arms straight into WAIT_START.
    fill_random();
    exp = model_word();
    arm_pulse("hold");
    ticks(10);
    drive_bits(NB);
    finish_frame("hold", exp);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("hold_arm_ignored_valid", 32'(fif.frame_valid), 1);
    check("hold_arm_ignored_busy", 32'(busy), 0);
    fif.frame_ack = 1'b1;
    arm = 1'b1;
    tick();
    fif.frame_ack = 1'b0;
    arm = 1'b0;
    check("ackarm_valid", 32'(fif.frame_valid), 0);
    check("ackarm_busy", 32'(busy), 1);
    fill_random();
    exp = model_word();
    ticks(10);
    drive_bits(NB);
    finish_frame("rearm", exp);
    ack_frame("rearm", exp);

    for (int r = 0; r < 2; r++) begin
      string nm = $sformatf("rand%0d", r);
      fill_random();
      exp = model_word();
      arm_pulse(nm);
      ticks(int'($urandom_range(3, 30)));
      drive_bits(NB);
      finish_frame(nm, exp);
      ack_frame(nm, exp);
    end

    // No response, then err_code persists until the next arm.
    arm_pulse("noresp");
    expect_error("noresp", 2'd1);
    ticks(20);
    check("noresp_code_held", 32'(err_code), 1);

    fill_random();
    arm_pulse("short");
    check("short_code_cleared", 32'(err_code), 0);
    ticks(10);
    drive_bits(10);
    expect_error("short", 2'd3);

    arm_pulse("stuck");
    ticks(10);
    drive_bits(5);
    line_in = 1'b0;
    expect_error("stuck", 2'd2);
    line_in = 1'b1;
    ticks(10);

    // Reset mid-frame drops the partial word without an error.
    arm_pulse("midrst");
    ticks(10);
    drive_bits(3);
    line_in = 1'b0;
    ticks(20);
    base = err_cnt;
    PRESERN = 1'b0;
    line_in = 1'b1;
    ticks(2);
    PRESERN = 1'b1;
    ticks(2);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_data", fif.frame_data, 0);
    check("midrst_err_code", 32'(err_code), 0);
    ticks(TMO + 50);
    check("midrst_no_err", err_cnt - base, 0);

`ifdef JOYBUS_RX_GLITCH_FILTER_EN
    fill_random();
    exp = model_word();
    arm_pulse("glitch");
    ticks(10);
    line_in = 1'b0;
    ticks(2);
    line_in = 1'b1;
    ticks(20);
    check("glitch_busy", 32'(busy), 1);
    drive_bits(NB);
    finish_frame("glitch", exp);
    ack_frame("glitch", exp);
`endif

    check("err_valid_overlap", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
